// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the pipeline MEM stage and mem_access_unit.
// The master side issues load/store requests; the slave side (the unit) completes them.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  misaligned;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, misaligned
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, misaligned
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-only big-endian data memory: byte/half/word loads
// and stores, with read-modify-write for sub-word stores and alignment checking.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      bus,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] READ      = 3'd1;
  localparam logic [2:0] LOAD_RESP = 3'd2;
  localparam logic [2:0] MERGE     = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  req_bad;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_result;
  logic [DATA_WIDTH-1:0] merged_word;

  assign req_bad = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  // Big-endian lanes: byte offset 0 is the most significant byte of the word.
  always_comb begin
    load_byte   = mem_rdata[31:24];
    merged_word = mem_rdata;
    case (addr_q[1:0])
      2'd0: load_byte = mem_rdata[31:24];
      2'd1: load_byte = mem_rdata[23:16];
      2'd2: load_byte = mem_rdata[15:8];
      default: load_byte = mem_rdata[7:0];
    endcase
    load_half = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (size_q)
      2'b00:   load_result = {{24{~uns_q & load_byte[7]}}, load_byte};
      2'b01:   load_result = {{16{~uns_q & load_half[15]}}, load_half};
      default: load_result = mem_rdata;
    endcase

    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merged_word[31:24] = wdata_q[7:0];
        2'd1: merged_word[23:16] = wdata_q[7:0];
        2'd2: merged_word[15:8]  = wdata_q[7:0];
        default: merged_word[7:0] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged_word[15:0] = wdata_q;
    end else begin
      merged_word[31:16] = wdata_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    misaligned_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata[15:0];
          if (req_bad) begin
            resp_valid_d = 1'b1;
            misaligned_d = 1'b1;
            resp_rdata_d = '0;
          end else if (bus.req_we && bus.req_size == 2'b10) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:      state_d = we_q ? MERGE : LOAD_RESP;
      LOAD_RESP: begin
        resp_rdata_d = load_result;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      MERGE: begin
        mem_wdata_d = merged_word;
        state_d     = WRITE;
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        state_d      = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      misaligned_q <= misaligned_d;
      resp_rdata_q <= resp_rdata_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Strobes decode from state so they drop the moment reset asserts.
  assign mem_re         = (state_q == READ);
  assign mem_we         = (state_q == WRITE);
  assign mem_addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata      = mem_wdata_q;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.misaligned = misaligned_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
